// File: rtl/and_seq_pkg.sv
// Shared constants, state encoding and step/gap tables for the AND sequence
// stimulus generator.
package and_seq_pkg;

    localparam int NUM_STEPS = 11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD_END
    } state_e;

    // (i2,i1) applied at step k; index 0 is the idle value
    function automatic logic [1:0] stepValue(input logic [3:0] k);
        case (k)
            4'd1:    return 2'b01;
            4'd2:    return 2'b11;
            4'd3:    return 2'b10;
            4'd4:    return 2'b00;
            4'd5:    return 2'b01;
            4'd6:    return 2'b11;
            4'd7:    return 2'b10;
            4'd8:    return 2'b00;
            4'd9:    return 2'b10;
            4'd10:   return 2'b11;
            4'd11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Ticks elapsed between the previous step and step k
    function automatic int unsigned gapTicks(input logic [3:0] k);
        case (k)
            4'd1, 4'd2, 4'd3, 4'd4: return 5;
            4'd5:    return 3;
            4'd6:    return 5;
            4'd7:    return 2;
            4'd8:    return 3;
            4'd9:    return 2;
            4'd10:   return 5;
            4'd11:   return 5;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/and_seq_gen.sv
// Replays the fixed 11-step i2/i1 pattern on request, with one down-counter
// timing the gap before each step and the final hold before done.
module and_seq_gen
    import and_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 4,
    parameter int DONE_HOLD   = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       i2,
    output logic       i1,
    output logic       step_stb,
    output logic [3:0] step,
    output logic       busy,
    output logic       done
);

    localparam longint MAX_LOAD =
        longint'(((DONE_HOLD > 5) ? DONE_HOLD : 5) * TICK_CYCLES - 1);

    generate
        if (TICK_CYCLES < 1 || DONE_HOLD < 1) begin : g_badParams
            $error("and_seq_gen: TICK_CYCLES and DONE_HOLD must be >= 1");
        end
        if (MAX_LOAD >= (longint'(1) << CNT_W)) begin : g_badCntW
            $error("and_seq_gen: CNT_W too narrow for the longest gap");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] tickLoad(input int unsigned ticks);
        return CNT_W'(ticks * unsigned'(TICK_CYCLES) - 1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic [3:0]       stepNext;
    logic             i2_q, i2_d;
    logic             i1_q, i1_d;
    logic             stb_q, stb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            i2_q    <= 1'b0;
            i1_q    <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            i2_q    <= i2_d;
            i1_q    <= i1_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        i2_d     = i2_q;
        i1_d     = i1_q;
        stb_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        stepNext = step_q + 4'd1;

        case (state_q)
            IDLE: begin
                // start together with abort is deliberately ignored
                if (start && !abort) begin
                    state_d = WAIT;
                    busy_d  = 1'b1;
                    cnt_d   = tickLoad(gapTicks(4'd1));
                end
            end

            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                    i2_d    = 1'b0;
                    i1_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    {i2_d, i1_d} = stepValue(stepNext);
                    step_d       = stepNext;
                    stb_d        = 1'b1;
                    if (stepNext == 4'(NUM_STEPS)) begin
                        state_d = HOLD_END;
                        cnt_d   = tickLoad(unsigned'(DONE_HOLD));
                    end else begin
                        cnt_d = tickLoad(gapTicks(stepNext + 4'd1));
                    end
                end
            end

            HOLD_END: begin
                if (abort || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                    i2_d    = 1'b0;
                    i1_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = !abort;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i2       = i2_q;
    assign i1       = i1_q;
    assign step_stb = stb_q;
    assign step     = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
